// File: rtl/spart_pkg.sv
// SPART shared definitions: receive FSM state encoding, default frame and
// divisor constants, and the 2-of-3 vote used by the majority sampler.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int unsigned BAUD_W      = 13;
  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned MIN_DIV     = 16;
  localparam logic [12:0] DEFAULT_DIV = 13'h1B2;  // 50 MHz / 434 -> 115200 baud

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_sync.sv
// Multi-flop synchroniser for SPART asynchronous inputs. Resets to 1 so that
// an idle-high line does not look like activity when reset is released.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   i_async   - asynchronous input
//   o_sync    - input retimed through STAGES flops
module spart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/spart_rx_deserializer.sv
// SPART UART receive front end: synchronises RX, validates the start bit,
// samples DATA_BITS data bits (LSB first) and the stop bit at mid-bit using
// the divisor latched at the start edge (minimum 16), and issues one-cycle
// rdy / frame_err strobes.
// Optional build macro SPART_RX_MAJORITY_EN: each sample becomes a 2-of-3 vote
// over counts 1, 0 and the following cycle; all decisions move one cycle later.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   RX         - asynchronous serial line, idles high
//   baud       - clock cycles per bit
//   rx_data    - last correctly framed byte
//   rdy        - one-cycle strobe, rx_data valid in the same cycle
//   frame_err  - one-cycle strobe when the stop bit is sampled low
//   busy       - high in any state except IDLE
module spart_rx_deserializer #(
  parameter int unsigned DATA_BITS   = spart_pkg::DATA_BITS,
  parameter int unsigned BAUD_W      = spart_pkg::BAUD_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic [BAUD_W-1:0]    baud,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 busy
);
  import spart_pkg::*;

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DATA_BITS - 1);
  localparam logic [BAUD_W-1:0] LP_MIN_DIV = BAUD_W'(MIN_DIV);
  localparam logic [BAUD_W-1:0] ONE        = BAUD_W'(1);

  logic w_rx;

  spart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (RX),
    .o_sync  (w_rx)
  );

  rx_state_e            r_state, w_state;
  logic [BAUD_W-1:0]    r_cnt, w_cnt;
  logic [BAUD_W-1:0]    r_div, w_div;
  logic [IDX_W-1:0]     r_idx, w_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [DATA_BITS-1:0] r_data, w_data;
  logic                 r_rdy, w_rdy;
  logic                 r_ferr, w_ferr;

  logic [BAUD_W-1:0] w_div_in;
  logic              w_in_frame;
  logic              w_cnt_zero;
  logic              w_evt;
  logic              w_bit;

  assign w_div_in   = (baud < LP_MIN_DIV) ? LP_MIN_DIV : baud;
  assign w_in_frame = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_cnt_zero = (r_cnt == '0);

`ifdef SPART_RX_MAJORITY_EN
  // Votes are gathered at count 1 and 0; the decision is made one cycle
  // later with the live sample as the third vote. The counter keeps its
  // reload at count 0, so bit spacing is unchanged.
  logic r_s1, r_s0, r_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b1;
      r_s0   <= 1'b1;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_in_frame && w_cnt_zero;
      if (r_cnt == ONE) r_s1 <= w_rx;
      if (w_cnt_zero)   r_s0 <= w_rx;
    end
  end

  assign w_evt = r_pend;
  assign w_bit = maj3(r_s1, r_s0, w_rx);
`else
  assign w_evt = w_in_frame && w_cnt_zero;
  assign w_bit = w_rx;
`endif

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_div   = r_div;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_data  = r_data;
    w_rdy   = 1'b0;
    w_ferr  = 1'b0;

    if (w_in_frame) begin
      w_cnt = w_cnt_zero ? (r_div - ONE) : (r_cnt - ONE);
    end

    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_div   = w_div_in;
          w_cnt   = (w_div_in >> 1) - ONE;
          w_idx   = '0;
          w_state = START;
        end
      end
      START: begin
        if (w_evt) w_state = w_bit ? IDLE : DATA;
      end
      DATA: begin
        if (w_evt) begin
          w_shift = DATA_BITS'({w_bit, r_shift} >> 1);
          if (r_idx == LAST_IDX) w_state = STOP;
          else                   w_idx   = r_idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (w_evt) begin
          if (w_bit) begin
            w_data  = r_shift;
            w_rdy   = 1'b1;
            w_state = IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_state = BREAK;
          end
        end
      end
      BREAK: begin
        if (w_rx) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= LP_MIN_DIV;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_div   <= w_div;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_rdy   <= w_rdy;
      r_ferr  <= w_ferr;
    end
  end

  assign rx_data   = r_data;
  assign rdy       = r_rdy;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_spart_rx_deserializer.sv
module tb_spart_rx_deserializer;

`ifdef SPART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX  = 1'b1;
  logic [12:0] baud = 13'd434;
  logic [7:0]  rx_data;
  logic        rdy, frame_err, busy;

  spart_rx_deserializer #(
    .DATA_BITS   (8),
    .BAUD_W      (13),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .baud      (baud),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 = rdy, 1 = frame_err
    logic [7:0] data;
    int         t;      // clock edge at which the strobe is consumed
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_rx = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Edge (counted from the first edge sampling RX low) at which a strobe is
  // high: 2 sync edges, 1 IDLE edge, half-bit to the start sample, then
  // 8 data + 1 stop bit periods.
  function automatic int lat(input int div);
    return SYNC + 1 + (div >> 1) + 9 * div + EXTRA;
  endfunction

  // Called at a negedge; drives one 8N1 frame with `div` cycles per bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int div, input bit track);
    exp_t e;
    int   e0;
    e0 = cyc + 1;
    RX = 1'b0;
    if (track) begin
      if (stop) begin
        exp_rx = d;
        e = '{0, d, e0 + lat(div)};
      end else begin
        e = '{1, exp_rx, e0 + lat(div)};
      end
      q.push_back(e);
    end
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (div) @(negedge clk);
    end
    RX = stop;
    repeat (div) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (rdy || frame_err)) begin
      check("strobe_exclusive", {63'd0, rdy & frame_err}, 64'd0);
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: rdy=%0b frame_err=%0b rx_data=0x%0h, expected none (cycle %0d)",
                 rdy, frame_err, rx_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_kind", rdy ? 64'd0 : 64'd1, 64'(e.kind));
        check("rx_data", 64'(rx_data), 64'(e.data));
        check("strobe_time", 64'(cyc + 1), 64'(e.t));
      end
    end
  end

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    n_err++;
    $display("FAIL watchdog: simulation exceeded 95000 cycles, expected completion");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int fall;

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_rx_data", 64'(rx_data), 64'h00);
    check("reset_rdy", 64'(rdy), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Stop bit low, then a held-low line: one frame_err, rx_data stays 0x00
    send_frame(8'h3C, 1'b0, 434, 1'b1);
    repeat (5000) @(negedge clk);
    check("break_busy_held", 64'(busy), 64'd1);
    RX = 1'b1;
    repeat (20) @(negedge clk);
    check("break_released_busy", 64'(busy), 64'd0);
    send_frame(8'h81, 1'b1, 434, 1'b1);
    repeat (50) @(negedge clk);

    // Nominal frame
    send_frame(8'hA5, 1'b1, 434, 1'b1);
    repeat (50) @(negedge clk);

    // 100-cycle glitch: START sample sees 1, busy falls at edge 219 after e0
    e0 = cyc + 1;
    RX = 1'b0;
    repeat (100) @(negedge clk);
    RX = 1'b1;
    fall = -1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        fall = cyc;
        break;
      end
      @(negedge clk);
    end
    check("glitch_busy_fall", 64'(fall), 64'(e0 + 219 + EXTRA));
    repeat (50) @(negedge clk);

    // Back-to-back frames, no idle gap: strobes 4340 apart
    send_frame(8'h55, 1'b1, 434, 1'b1);
    send_frame(8'hAA, 1'b1, 434, 1'b1);
    repeat (50) @(negedge clk);

    // Divisor below minimum is clamped to 16
    baud = 13'd5;
    send_frame(8'h0F, 1'b1, 16, 1'b1);
    repeat (20) @(negedge clk);
    baud = 13'd434;
    repeat (10) @(negedge clk);

    // Divisor change mid-frame is ignored until the next frame
    fork
      send_frame(8'h6B, 1'b1, 434, 1'b1);
      begin
        repeat (1500) @(negedge clk);
        baud = 13'd868;
      end
    join
    baud = 13'd434;
    repeat (50) @(negedge clk);

    // Reset during the data bits of 0xFF: no strobe, busy drops immediately
    fork
      send_frame(8'hFF, 1'b1, 434, 1'b0);
      begin
        repeat (434 * 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
      end
    join
    repeat (50) @(negedge clk);
    send_frame(8'h12, 1'b1, 434, 1'b1);

    // Drain
    for (int i = 0; i < 10000 && q.size() != 0; i++) @(negedge clk);
    check("pending_expected_strobes", 64'(q.size()), 64'd0);
    check("final_rx_data", 64'(rx_data), 64'h12);

    summary();
    $finish;
  end

endmodule
